// File: rtl/case_5_mul_pipe_hs.sv
// case_5_mul_pipe_hs: pipelined multiplier with a valid/ready handshake and a
// global clock enable. The whole pipe advances as one unit when the output
// slot is free or being drained. Operand signedness is per operand, and the
// product is narrowed to dout_WIDTH.
// Build option: define MUL_SAT_EN for saturating narrowing with overflow flag.
// Without it, narrowing wraps and ovf is tied to zero.
module case_5_mul_pipe_hs #(
  parameter int ID          = 1,
  parameter int NUM_STAGE   = 3,
  parameter int din0_WIDTH  = 11,
  parameter int din1_WIDTH  = 4,
  parameter int dout_WIDTH  = 11,
  parameter int din0_SIGNED = 1,
  parameter int din1_SIGNED = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  ovf
);

  localparam int W        = din0_WIDTH + din1_WIDTH;
  localparam bit P_SIGNED = (din0_SIGNED != 0) || (din1_SIGNED != 0);
  // Only the product bits that the narrowing stage looks at are built.
`ifdef MUL_SAT_EN
  localparam int PW = W;
`else
  localparam int PW = (dout_WIDTH < W) ? dout_WIDTH : W;
`endif

  // Configurations outside NUM_STAGE 1..8 are unsupported. ID is an instance
  // tag with no functional effect.
  if (ID < 0 || NUM_STAGE < 1 || NUM_STAGE > 8) begin : g_cfg_unsupported
  end

  // ---------------------------------------------------------------------------
  // Full product. Each operand gets one extra MSB. That bit is a copy of the
  // sign for a signed operand and 0 for an unsigned one. Both operands can
  // then be multiplied as signed numbers. The low W bits hold P exactly.
  // ---------------------------------------------------------------------------
  logic signed [din0_WIDTH:0] a_ext;
  logic signed [din1_WIDTH:0] b_ext;
  logic signed [PW-1:0]       a_w;
  logic signed [PW-1:0]       b_w;
  logic signed [PW-1:0]       p;

  assign a_ext = {(din0_SIGNED != 0) && din0[din0_WIDTH-1], din0};
  assign b_ext = {(din1_SIGNED != 0) && din1[din1_WIDTH-1], din1};
  assign a_w   = PW'(a_ext);
  assign b_w   = PW'(b_ext);
  assign p     = a_w * b_w;

  // ---------------------------------------------------------------------------
  // Narrowing to dout_WIDTH
  // ---------------------------------------------------------------------------
  logic [dout_WIDTH-1:0] nar;
`ifdef MUL_SAT_EN
  logic                  nar_ovf;
`endif

  if (dout_WIDTH >= W) begin : g_extend
    // The result is wide enough, so extend P with its sign (or with zeros).
    assign nar = P_SIGNED ? dout_WIDTH'(p) : dout_WIDTH'($unsigned(p));
`ifdef MUL_SAT_EN
    assign nar_ovf = 1'b0;
`endif
  end else begin : g_narrow
`ifdef MUL_SAT_EN
    if (P_SIGNED) begin : g_sat_s
      localparam logic [dout_WIDTH-1:0] S_MIN = dout_WIDTH'(1) << (dout_WIDTH - 1);
      // P fits only when every bit from the result MSB upward is equal.
      logic [W-dout_WIDTH:0] top;
      assign top     = p[W-1:dout_WIDTH-1];
      assign nar_ovf = !((&top) || !(|top));
      assign nar     = nar_ovf ? (p[W-1] ? S_MIN : ~S_MIN) : p[dout_WIDTH-1:0];
    end else begin : g_sat_u
      assign nar_ovf = |p[W-1:dout_WIDTH];
      assign nar     = nar_ovf ? '1 : p[dout_WIDTH-1:0];
    end
`else
    // Wrapping: p is already exactly dout_WIDTH bits wide.
    assign nar = p;
`endif
  end

  // ---------------------------------------------------------------------------
  // Pipeline
  // ---------------------------------------------------------------------------
  logic                  adv;
  logic [NUM_STAGE-1:0]  vld_q, vld_d;
  logic [dout_WIDTH-1:0] dat_q [NUM_STAGE];
  logic [dout_WIDTH-1:0] dat_d [NUM_STAGE];
`ifdef MUL_SAT_EN
  logic [NUM_STAGE-1:0]  ovf_q, ovf_d;
`endif

  // The whole pipe advances when the output slot is empty or is being taken.
  // It never advances while reset is asserted.
  assign adv      = ce && (!vld_q[NUM_STAGE-1] || out_ready) && !reset;
  assign in_ready = adv;

  // Next-state: shift valid bits on advance. Data follows only real items,
  // so a bubble leaves the previous stage contents in place.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    vld_d = vld_q;
    dat_d = dat_q;
`ifdef MUL_SAT_EN
    ovf_d = ovf_q;
`endif
    if (adv) begin
      vld_d[0] = in_valid;
      if (in_valid) begin
        dat_d[0] = nar;
`ifdef MUL_SAT_EN
        ovf_d[0] = nar_ovf;
`endif
      end
      for (int i = 1; i < NUM_STAGE; i++) begin
        vld_d[i] = vld_q[i-1];
        if (vld_q[i-1]) begin
          dat_d[i] = dat_q[i-1];
`ifdef MUL_SAT_EN
          ovf_d[i] = ovf_q[i-1];
`endif
        end
      end
    end
  end

  // State registers. An asynchronous reset discards every in-flight item.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      // NOTE: stage data is reset too, because dout must read 0 straight out of reset.
      for (int i = 0; i < NUM_STAGE; i++) dat_q[i] <= '0;
`ifdef MUL_SAT_EN
      ovf_q <= '0;
`endif
    end else begin
      // NOTE: sequential state is updated with non-blocking assignments only.
      vld_q <= vld_d;
      dat_q <= dat_d;
`ifdef MUL_SAT_EN
      ovf_q <= ovf_d;
`endif
    end
  end

  assign out_valid = vld_q[NUM_STAGE-1];
  assign dout      = dat_q[NUM_STAGE-1];
`ifdef MUL_SAT_EN
  assign ovf       = ovf_q[NUM_STAGE-1];
`else
  assign ovf       = 1'b0;
`endif

endmodule
